serial_compare_ctrl: RTL and testbench
======================================

// Module: serial_compare_ctrl
// PURPOSE
//  Sequences a 2-bit digit magnitude compare over WIDTH-bit unsigned operands,
//  MSB digit first, one 2-bit digit per clock. Sits in front of the 2-bit
//  comparator datapath so wide compares reuse one digit-compare stage.
//  Uses a start/busy/done handshake and holds registered gt/lt/eq results.
// PARAMETERS
//  WIDTH      8  operand width in bits; even, >=2; DIGITS = WIDTH/2
//  EARLY_EXIT 1  1: stop at first unequal digit; 0: always scan all DIGITS
// PORTS
//  clk    in   1      clock, rising edge
//  rst    in   1      synchronous reset, active-high
//  start  in   1      request; accepted only when busy==0
//  a      in   WIDTH  operand A, sampled on the accepting edge only
//  b      in   WIDTH  operand B, sampled on the accepting edge only
//  busy   out  1      compare in progress
//  done   out  1      one-cycle pulse: gt/lt/eq valid from this cycle
//  gt     out  1      A > B (registered, held)
//  lt     out  1      A < B (registered, held)
//  eq     out  1      A == B (registered, held)
// BEHAVIOUR
//  - Reset (rst high at edge): state=IDLE; busy, done, gt, lt, eq all 0;
//    the operand regs and digit index are don't-care. Reset wins over all.
//  - States: IDLE, SCAN. The digit index idx is log2(DIGITS) bits, min 1.
//  - IDLE: on an edge with start=1: capture a,b; idx=DIGITS-1; gt=lt=eq=0;
//    busy=1; go to SCAN. Otherwise hold outputs; done=0.
//  - SCAN, each edge: compare A[2*idx+1:2*idx] with B[2*idx+1:2*idx].
//    * If the digits differ and EARLY_EXIT=1: set gt or lt from that digit,
//      then busy=0, done=1, go to IDLE.
//    * If the digits differ and EARLY_EXIT=0: latch gt or lt on the first
//      differing digit only. Later digits do not change the latched result.
//    * When idx==0: finish. If no digit differed, set eq=1. Then busy=0,
//      done=1, go to IDLE. Otherwise idx decrements by 1.
//  - Exactly one of gt/lt/eq is 1 after done. All are 0 while busy.
//  - done is high for exactly one cycle, the cycle after the deciding edge.
//  - Latency, counting start high as cycle 0: busy is high from cycle 1.
//    Earliest done is cycle 2 (MSB digit differs, EARLY_EXIT=1).
//    Worst-case done is cycle DIGITS+1; with EARLY_EXIT=0 it is always
//    cycle DIGITS+1.
//  - start while busy=1 is ignored: no queueing, and operands are not resampled.
//  - start high in the done cycle is accepted (busy=0 then), so compares
//    can run back-to-back. Results clear to 0 on that accepting edge.
//  - a/b may change freely after the accepting edge without effect.
//  - Reset mid-SCAN aborts the compare; no done pulse is produced.
// TESTING (WIDTH=8)
//  - a=8'hB4,b=8'h74,start 1 cyc, EARLY_EXIT=1 -> busy cyc1, done cyc2,
//    gt=1 lt=0 eq=0.
//  - a=b=8'h5A -> done at cyc5, eq=1 gt=0 lt=0; with EARLY_EXIT=0 the same.
//  - a=8'h12,b=8'h13 -> differs at the LSB digit only: done cyc5, lt=1.
//    With EARLY_EXIT=0, a=8'hC0,b=8'h3F -> done cyc5, gt=1 (not overwritten).
//  - Start a=8'h00,b=8'hFF; hold start high and change a/b every cycle while
//    busy -> single compare, lt=1, one done pulse.
//  - Back-to-back: start held high through done -> second compare accepted
//    in the done cycle, outputs 0 the next cycle, new result later.
//  - Assert rst in cyc3 of an equal compare -> busy=0, done never pulses,
//    gt=lt=eq=0. A subsequent start works normally.

Source files
------------

// File: rtl/serial_compare_ctrl.sv
// ---------------------------------------------------------------------------
// serial_compare_ctrl
// Compares two WIDTH-bit unsigned operands one 2-bit digit per clock, most
// significant digit first, so a wide magnitude compare can reuse a single
// 2-bit comparator stage. Uses a start/busy/done handshake and holds the
// registered gt/lt/eq result until the next accepted start.
//
// Parameters
//   WIDTH      operand width in bits (even, >= 2); DIGITS = WIDTH/2
//   EARLY_EXIT 1: stop at the first unequal digit, 0: always scan all digits
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous reset, active-high
//   start  in   compare request, accepted only while busy is low
//   a, b   in   operands, sampled on the accepting edge only
//   busy   out  compare in progress
//   done   out  one-cycle pulse, result valid from this cycle
//   gt     out  A > B  (registered, held)
//   lt     out  A < B  (registered, held)
//   eq     out  A == B (registered, held)
// ---------------------------------------------------------------------------
module serial_compare_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int unsigned DIGITS = WIDTH / 2;
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [IDX_W-1:0]   idx_q;
    logic               diff_q;     // an unequal digit has already been seen
    logic               res_gt_q;   // result of the first unequal digit
    logic               res_lt_q;
    logic               busy_q;
    logic               done_q;
    logic               gt_q;
    logic               lt_q;
    logic               eq_q;

    logic [1:0]         a_dig_c;
    logic [1:0]         b_dig_c;
    logic               dig_ne_c;
    logic               dig_gt_c;
    logic               last_c;
    logic               final_gt_c;
    logic               final_lt_c;
    logic               final_eq_c;

    // Current digit compare and end-of-scan decision.
    always_comb begin
        a_dig_c    = a_q[{idx_q, 1'b0} +: 2];
        b_dig_c    = b_q[{idx_q, 1'b0} +: 2];
        dig_ne_c   = (a_dig_c != b_dig_c);
        dig_gt_c   = (a_dig_c > b_dig_c);
        last_c     = (idx_q == '0) || (EARLY_EXIT && dig_ne_c);
        // An earlier unequal digit always outranks the current one.
        final_gt_c = diff_q ? res_gt_q : (dig_ne_c && dig_gt_c);
        final_lt_c = diff_q ? res_lt_q : (dig_ne_c && !dig_gt_c);
        final_eq_c = !diff_q && !dig_ne_c;
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            diff_q   <= 1'b0;
            res_gt_q <= 1'b0;
            res_lt_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        idx_q    <= IDX_W'(DIGITS - 1);
                        diff_q   <= 1'b0;
                        res_gt_q <= 1'b0;
                        res_lt_q <= 1'b0;
                        gt_q     <= 1'b0;
                        lt_q     <= 1'b0;
                        eq_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    // Keep the first unequal digit hidden until the scan ends.
                    if (dig_ne_c && !diff_q) begin
                        diff_q   <= 1'b1;
                        res_gt_q <= dig_gt_c;
                        res_lt_q <= !dig_gt_c;
                    end
                    if (last_c) begin
                        gt_q    <= final_gt_c;
                        lt_q    <= final_lt_c;
                        eq_q    <= final_eq_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_compare_ctrl
// Directed bench for serial_compare_ctrl at WIDTH=8. One instance with
// EARLY_EXIT=1 (suffix _e) and one with EARLY_EXIT=0 (suffix _f) share
// clock, reset and operands; each has its own start. Outputs are checked as
// {busy,done,gt,lt,eq} one time unit after every rising edge; "cycle N"
// counts from the cycle in which start is first driven high (cycle 0).
// ---------------------------------------------------------------------------
module tb_serial_compare_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_e;
    logic       start_f;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy_e, done_e, gt_e, lt_e, eq_e;
    logic       busy_f, done_f, gt_f, lt_f, eq_f;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
        .clk(clk), .rst(rst), .start(start_e), .a(a), .b(b),
        .busy(busy_e), .done(done_e), .gt(gt_e), .lt(lt_e), .eq(eq_e)
    );

    serial_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_f (
        .clk(clk), .rst(rst), .start(start_f), .a(a), .b(b),
        .busy(busy_f), .done(done_f), .gt(gt_f), .lt(lt_f), .eq(eq_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int cyc,
                         input logic [4:0] obs, input logic [4:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc%0d {busy,done,gt,lt,eq} observed=%b expected=%b",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input int cyc,
                              input logic [4:0] exp_e, input logic [4:0] exp_f);
        check({tag, "/E"}, cyc, {busy_e, done_e, gt_e, lt_e, eq_e}, exp_e);
        check({tag, "/F"}, cyc, {busy_f, done_f, gt_f, lt_f, eq_f}, exp_f);
    endtask

    // One-cycle start on both instances, then six checked cycles.
    task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [29:0] ee, input logic [29:0] ef);
        a       = av;
        b       = bv;
        start_e = 1'b1;
        start_f = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start_e = 1'b0;
            start_f = 1'b0;
            check_both(tag, c, ee[29-5*(c-1) -: 5], ef[29-5*(c-1) -: 5]);
        end
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] e8;
        logic [29:0] ee;
        logic [29:0] ef;

        rst     = 1'b1;
        start_e = 1'b0;
        start_f = 1'b0;
        a       = 8'h00;
        b       = 8'h00;
        tick();
        tick();
        check_both("reset", 0, 5'b00000, 5'b00000);
        rst = 1'b0;
        tick();
        check_both("post_reset", 0, 5'b00000, 5'b00000);

        // MSB digit differs: early exit finishes in cycle 2, full scan in 5.
        run_cmp("b4_gt_74", 8'hB4, 8'h74,
                {5'b10000, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100},
                {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b01100, 5'b00100});

        // Equal operands: both modes scan every digit.
        run_cmp("5a_eq", 8'h5A, 8'h5A,
                {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b01001, 5'b00001},
                {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b01001, 5'b00001});

        // Only the LSB digit differs.
        run_cmp("12_lt_13", 8'h12, 8'h13,
                {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b01010, 5'b00010},
                {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b01010, 5'b00010});

        // MSB says gt, later digits say lt: result must stay gt.
        run_cmp("c0_gt_3f", 8'hC0, 8'h3F,
                {5'b10000, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100},
                {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b01100, 5'b00100});

        // Start held while busy and operands flipped to a>b: no resample.
        a       = 8'h00;
        b       = 8'hFF;
        start_e = 1'b1;
        start_f = 1'b1;
        ee = {5'b10000, 5'b01010, 5'b00010, 5'b00010, 5'b00010, 5'b00010};
        ef = {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b01010, 5'b00010};
        for (int c = 1; c <= 6; c++) begin
            tick();
            a       = 8'(8'hF0 + c);
            b       = 8'h01;
            start_e = (c < 2);
            start_f = (c < 4);
            check_both("hold_start", c, ee[29-5*(c-1) -: 5], ef[29-5*(c-1) -: 5]);
        end

        // Back-to-back on the early-exit instance; second start accepted in
        // the done cycle with new operands 12/13.
        a       = 8'hB4;
        b       = 8'h74;
        start_e = 1'b1;
        start_f = 1'b0;
        e8 = {5'b10000, 5'b01100, 5'b10000, 5'b10000,
              5'b10000, 5'b10000, 5'b01010, 5'b00010};
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 2) begin
                a = 8'h12;
                b = 8'h13;
            end
            start_e = (c < 3);
            check_both("b2b", c, e8[39-5*(c-1) -: 5], 5'b00010);
        end

        // Reset asserted in cycle 3 of an equal compare: no done pulse.
        a       = 8'h5A;
        b       = 8'h5A;
        start_e = 1'b1;
        start_f = 1'b1;
        ee = {5'b10000, 5'b10000, 5'b10000, 5'b00000, 5'b00000, 5'b00000};
        for (int c = 1; c <= 6; c++) begin
            tick();
            start_e = 1'b0;
            start_f = 1'b0;
            if (c == 3) rst = 1'b1;
            if (c == 4) rst = 1'b0;
            check_both("abort", c, ee[29-5*(c-1) -: 5], ee[29-5*(c-1) -: 5]);
        end

        // Normal compare after the abort; second digit decides lt.
        run_cmp("12_lt_34", 8'h12, 8'h34,
                {5'b10000, 5'b10000, 5'b01010, 5'b00010, 5'b00010, 5'b00010},
                {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b01010, 5'b00010});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
